// File: rtl/step_ctrl_pkg.sv
// Shared types for the step-controlled processor decoder: opcode and step encodings and
// instruction-register field layout {op, rx, ry}.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MV  = 2'b00,
        OP_MVI = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    // op occupies the top OP_W bits of IR; its MSB marks the reserved opcode space
    localparam int unsigned OP_W   = 3;
    localparam int unsigned OP_RSV = OP_W - 1;

    function automatic int unsigned reg_idx_w(input int unsigned nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary register index to N-bit one-hot select, all zeros when disabled.
module onehot_dec #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic         en,
    input  logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (idx == W'(i));
        end
    end

endmodule

// File: rtl/step_ctrl_decoder.sv
// Per-step control strobe decoder, IR holder and step-sequence checker for the simple processor.
// Optional ILLEGAL_OPCODE_TRAP_EN adds a sticky IllegalOp trap that stalls the block until reset.
module step_ctrl_decoder
    import step_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 8,
    parameter int unsigned IR_W = 9
) (
    input  logic            CLKb,
    input  logic            CLRb,
    input  logic            Run,
    input  logic [IR_W-1:0] DIN,
    input  logic [1:0]      Tstep,
    output logic            CntClr,
    output logic            IRin,
    output logic [NREG-1:0] Rout,
    output logic [NREG-1:0] Rin,
    output logic            DINout,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic            AddSub,
    output logic            Done,
`ifdef ILLEGAL_OPCODE_TRAP_EN
    output logic            IllegalOp,
`endif
    output logic            SeqErr
);

    localparam int unsigned RW = reg_idx_w(NREG);

    logic [IR_W-1:0] ir_q;
    logic [1:0]      exp_q;
    logic            seq_err_q;
    logic            hold;

    step_t          step;
    op_t            opc;
    logic           rsv;
    logic [RW-1:0]  rx;
    logic [RW-1:0]  ry;
    logic           rout_en;
    logic           rin_en;
    logic [RW-1:0]  rout_sel;

    assign step = step_t'(Tstep);
    assign rsv  = ir_q[IR_W-OP_W+OP_RSV];
    assign opc  = op_t'(ir_q[IR_W-OP_W +: 2]);
    assign rx   = ir_q[2*RW-1 -: RW];
    assign ry   = ir_q[RW-1:0];

`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic illegal_q;
    assign IllegalOp = illegal_q;
    assign hold      = !CLRb || illegal_q;
`else
    assign hold      = !CLRb;
`endif

    assign SeqErr = seq_err_q;

    always_comb begin
        IRin     = 1'b0;
        DINout   = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        AddSub   = 1'b0;
        Done     = 1'b0;
        rout_en  = 1'b0;
        rin_en   = 1'b0;
        rout_sel = rx;
        unique case (step)
            T0: IRin = Run;
            T1: begin
                if (rsv) begin
                    Done = 1'b1;
                end else begin
                    unique case (opc)
                        OP_MV: begin
                            rout_en  = 1'b1;
                            rout_sel = ry;
                            rin_en   = 1'b1;
                            Done     = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            rin_en = 1'b1;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            rout_en = 1'b1;
                            Ain     = 1'b1;
                        end
                    endcase
                end
            end
            T2: begin
                if (!rsv && (opc == OP_ADD || opc == OP_SUB)) begin
                    rout_en  = 1'b1;
                    rout_sel = ry;
                    Gin      = 1'b1;
                    AddSub   = (opc == OP_SUB);
                end
            end
            T3: begin
                if (!rsv && (opc == OP_ADD || opc == OP_SUB)) begin
                    Gout   = 1'b1;
                    rin_en = 1'b1;
                    Done   = 1'b1;
                end
            end
        endcase
        CntClr = Done || (step == T0 && !Run);
        // Reset or trap: everything quiet, counter pinned at T0
        if (hold) begin
            IRin    = 1'b0;
            DINout  = 1'b0;
            Ain     = 1'b0;
            Gin     = 1'b0;
            Gout    = 1'b0;
            AddSub  = 1'b0;
            Done    = 1'b0;
            rout_en = 1'b0;
            rin_en  = 1'b0;
            CntClr  = 1'b1;
        end
    end

    onehot_dec #(
        .N (NREG),
        .W (RW)
    ) u_rout_dec (
        .en     (rout_en),
        .idx    (rout_sel),
        .onehot (Rout)
    );

    onehot_dec #(
        .N (NREG),
        .W (RW)
    ) u_rin_dec (
        .en     (rin_en),
        .idx    (rx),
        .onehot (Rin)
    );

    always_ff @(negedge CLKb or negedge CLRb) begin
        if (!CLRb) begin
            ir_q      <= '0;
            exp_q     <= 2'd0;
            seq_err_q <= 1'b0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            if (IRin) begin
                ir_q <= DIN;
            end
            exp_q <= CntClr ? 2'd0 : exp_q + 2'd1;
            if (Tstep != exp_q) begin
                seq_err_q <= 1'b1;
            end
`ifdef ILLEGAL_OPCODE_TRAP_EN
            if (step == T1 && rsv) begin
                illegal_q <= 1'b1;
            end
`endif
        end
    end

endmodule
